// File: rtl/riscv_soft_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word-indexed request per cycle
// to the instruction cache, and buffers responses in a 2-entry FIFO for decode.
module riscv_soft_fetch_unit #(
    parameter int                 XPR_LEN  = 32,
    parameter logic [XPR_LEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_fetch_req_ready,
    output logic               i_fetch_req_valid,
    output logic [XPR_LEN-1:0] i_fetch_req_addr,
    input  logic               i_fetch_resp_valid,
    input  logic [XPR_LEN-1:0] i_fetch_resp_data,
    input  logic               redirect_valid,
    input  logic [XPR_LEN-1:0] redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XPR_LEN-1:0] inst_data,
    output logic [XPR_LEN-1:0] inst_pc
);

    localparam int DEPTH = 2;

    logic [XPR_LEN-1:0] pc_reg;
    logic [XPR_LEN-1:0] inflight_pc_reg;
    logic               inflight_reg;
    logic               kill_reg;
    logic               rd_ptr_reg;
    logic               wr_ptr_reg;
    logic [1:0]         count_reg;
    logic [XPR_LEN-1:0] buf_pc_reg   [DEPTH];
    logic [XPR_LEN-1:0] buf_inst_reg [DEPTH];

    logic               pop;
    logic               push;
    logic               accept;
    logic [2:0]         credits_used;
    logic [XPR_LEN-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~XPR_LEN'(3);

    // A redirect hides the (about to be flushed) head so decode never consumes it.
    assign inst_valid = !reset && !redirect_valid && (count_reg != 2'd0);
    assign pop        = inst_valid && inst_ready;

    // Buffered entries plus the in-flight request must leave a slot for every
    // response, so the FIFO can never be pushed while full.
    assign credits_used      = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign i_fetch_req_valid = !reset && !redirect_valid && (credits_used < 3'd2);
    assign i_fetch_req_addr  = pc_reg >> 2;
    assign accept            = i_fetch_req_valid && i_fetch_req_ready;

    assign push = !reset && !redirect_valid && i_fetch_resp_valid
                  && inflight_reg && !kill_reg;

    assign inst_data = reset ? '0 : buf_inst_reg[rd_ptr_reg];
    assign inst_pc   = reset ? '0 : buf_pc_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_reg[wr_ptr_reg]   <= inflight_pc_reg;
            buf_inst_reg[wr_ptr_reg] <= i_fetch_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            kill_reg        <= 1'b0;
            rd_ptr_reg      <= 1'b0;
            wr_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
        end else if (redirect_valid) begin
            pc_reg       <= redirect_pc_aligned;
            inflight_reg <= 1'b0;
            kill_reg     <= inflight_reg;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            if (accept) begin
                inflight_reg    <= 1'b1;
                inflight_pc_reg <= pc_reg;
                kill_reg        <= 1'b0;
                pc_reg          <= pc_reg + XPR_LEN'(4);
            end else begin
                inflight_reg <= 1'b0;
            end

            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_soft_fetch_unit.sv
// Self-checking bench for riscv_soft_fetch_unit: directed scenarios plus a random
// phase, checked against an occupancy/stream model of the fetch stage.
module tb_riscv_soft_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_fetch_req_ready;
    logic        i_fetch_req_valid;
    logic [31:0] i_fetch_req_addr;
    logic        i_fetch_resp_valid;
    logic [31:0] i_fetch_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        spurious;

    int errors = 0;
    int checks = 0;

    // Reference model: instructions accepted but not yet consumed, whether the
    // previous cycle's request is still in flight, next fetch pc, next expected pc.
    int          outstanding;
    int          acc_prev;
    logic [31:0] fetch_pc;
    logic [31:0] exp_pc;

    riscv_soft_fetch_unit #(.XPR_LEN(32), .RESET_PC(RESET_PC)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_fetch_req_ready  (i_fetch_req_ready),
        .i_fetch_req_valid  (i_fetch_req_valid),
        .i_fetch_req_addr   (i_fetch_req_addr),
        .i_fetch_resp_valid (i_fetch_resp_valid),
        .i_fetch_resp_data  (i_fetch_resp_data),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .inst_valid         (inst_valid),
        .inst_ready         (inst_ready),
        .inst_data          (inst_data),
        .inst_pc            (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        return 32'h1000_0000 + {2'b00, idx};
    endfunction

    // Cache with fixed one-cycle latency; can also emit an unsolicited response.
    always @(posedge clk) begin
        i_fetch_resp_valid <= (i_fetch_req_valid && i_fetch_req_ready) || spurious;
        i_fetch_resp_data  <= spurious ? 32'hDEAD_BEEF : mem_word(i_fetch_req_addr[29:0]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic exp_valid, exp_req, pop_e, acc;
        if (reset) begin
            chk("rst_req_valid", {31'd0, i_fetch_req_valid}, 32'd0);
            chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
            chk("rst_inst_pc", inst_pc, 32'd0);
            chk("rst_inst_data", inst_data, 32'd0);
            outstanding = 0;
            acc_prev    = 0;
            fetch_pc    = RESET_PC;
            exp_pc      = RESET_PC;
            return;
        end
        if (redirect_valid) begin
            chk("redir_inst_valid", {31'd0, inst_valid}, 32'd0);
            chk("redir_req_valid", {31'd0, i_fetch_req_valid}, 32'd0);
            fetch_pc    = redirect_pc & ~32'd3;
            exp_pc      = fetch_pc;
            outstanding = 0;
            acc_prev    = 0;
            return;
        end
        exp_valid = (outstanding - acc_prev) > 0;
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_valid});
        pop_e   = exp_valid && inst_ready;
        exp_req = (outstanding - int'(pop_e)) < 2;
        chk("req_valid", {31'd0, i_fetch_req_valid}, {31'd0, exp_req});
        if (i_fetch_req_valid) chk("req_addr", i_fetch_req_addr, fetch_pc >> 2);
        if (pop_e) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc[31:2]));
            exp_pc = exp_pc + 32'd4;
        end
        acc = exp_req && i_fetch_req_ready;
        if (acc) fetch_pc = fetch_pc + 32'd4;
        outstanding = outstanding + int'(acc) - int'(pop_e);
        acc_prev    = int'(acc);
    endtask

    // Check the current cycle at the falling edge, then move just past the next rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; inst_ready = 1'b0; i_fetch_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; spurious = 1'b0;
        outstanding = 0; acc_prev = 0; fetch_pc = RESET_PC; exp_pc = RESET_PC;
        ticks(2);

        // First fetch latency and full throughput
        reset = 1'b0; inst_ready = 1'b1; #1;
        chk("first_req_c0", {31'd0, i_fetch_req_valid}, 32'd1);
        chk("first_addr_c0", i_fetch_req_addr, 32'd0);
        tick(); #1;
        chk("first_valid_c1", {31'd0, inst_valid}, 32'd0);
        tick(); #1;
        chk("first_valid_c2", {31'd0, inst_valid}, 32'd1);
        chk("first_pc_c2", inst_pc, 32'd0);
        chk("first_data_c2", inst_data, 32'h1000_0000);
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("stream_valid", {31'd0, inst_valid}, 32'd1);
        end
        tick();

        // Backpressure after reset, with an unsolicited response mid-stall
        reset = 1'b1; tick();
        reset = 1'b0; inst_ready = 1'b0;
        ticks(5);
        i_fetch_req_ready = 1'b0; spurious = 1'b1; tick();
        i_fetch_req_ready = 1'b1; spurious = 1'b0;
        ticks(4); #1;
        chk("bp_req_valid", {31'd0, i_fetch_req_valid}, 32'd0);
        chk("bp_head_pc", inst_pc, 32'd0);
        chk("bp_next_addr", i_fetch_req_addr, 32'd2);
        inst_ready = 1'b1;
        ticks(6);

        // Fetch stall: request address must hold
        i_fetch_req_ready = 1'b0;
        ticks(3);
        i_fetch_req_ready = 1'b1;
        ticks(5);

        // Redirect with buffered entries; unaligned target
        inst_ready = 1'b0; ticks(2);
        redirect_valid = 1'b1; redirect_pc = 32'h203; tick();
        redirect_valid = 1'b0; inst_ready = 1'b1; #1;
        chk("redir_n1_req", {31'd0, i_fetch_req_valid}, 32'd1);
        chk("redir_n1_addr", i_fetch_req_addr, 32'h80);
        tick(); #1;
        chk("redir_n2_valid", {31'd0, inst_valid}, 32'd0);
        tick(); #1;
        chk("redir_n3_valid", {31'd0, inst_valid}, 32'd1);
        chk("redir_n3_pc", inst_pc, 32'h200);
        ticks(4);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
        redirect_valid = 1'b0;
        ticks(2); #1;
        chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        tick(); #1;
        chk("wrap_pc1", inst_pc, 32'h0);
        ticks(3);

        // Reset with a buffered entry and a request in flight
        inst_ready = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; inst_ready = 1'b1; #1;
        chk("rst_mid_valid", {31'd0, inst_valid}, 32'd0);
        ticks(2); #1;
        chk("rst_mid_first_pc", inst_pc, RESET_PC);
        tick();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            inst_ready        = ($urandom_range(0, 9) < 7);
            i_fetch_req_ready = ($urandom_range(0, 9) < 8);
            spurious          = !i_fetch_req_ready && ($urandom_range(0, 3) == 0);
            redirect_valid    = ($urandom_range(0, 19) == 0);
            redirect_pc       = $urandom;
            reset             = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; redirect_valid = 1'b0; spurious = 1'b0;
        ticks(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
